cache_kv_controller: RTL and testbench
======================================

Name: cache_kv_controller

Overview:
- Cache controller directly downstream of the OBI cache interface: accepts one operation (GET, UPSERT, DELETE) with key and value, executes it against an internal fully-associative key/value store, and returns the success flag and read data.
- Fixed-latency linear search, one entry per cycle.
- Drives the interface's ready and op_succ inputs and its result-value path.

Parameters:
- ARCHITECTURE, 64, interface register width; key width = ARCHITECTURE-3, value width = 2*ARCHITECTURE.
- NUM_ENTRIES, 8, number of key/value slots (>=2); IDX_W = $clog2(NUM_ENTRIES).

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- op_valid_in  in  1  single-cycle start strobe, sampled only while ready_out=1
- operation_in  in  3  ctrl_types_pkg::operation_e
- key_in  in  ARCHITECTURE-3  lookup key
- value_in  in  2*ARCHITECTURE  write data for UPSERT
- ready_out  out  1  controller idle, will accept op_valid_in
- done_out  out  1  one-cycle pulse, result outputs valid
- op_succ_out  out  1  success of last operation, held until next done
- result_value_out  out  2*ARCHITECTURE  GET data, held until next done
- occupancy_out  out  IDX_W+1  number of valid entries

Interface statement (already decided): one clock, clk; reset rst is asynchronous and active-high.

Behaviour:
- Reset (async, any time including mid-operation):
  - state=IDLE, all entry valid bits=0, ready_out=1, done_out=0, op_succ_out=0, result_value_out=0, occupancy_out=0.
  - Key/value storage contents need no reset.
- Operation encoding: NOOP=3'd0, GET=3'd1, UPSERT=3'd2, DELETE=3'd3; codes 4-7 are illegal.
- States: IDLE, SEARCH, COMMIT, DONE.
- IDLE:
  - ready_out=1.
  - On op_valid_in=1, capture op/key/value; clear hit flag, free-found flag and scan index.
  - GET/UPSERT/DELETE -> SEARCH. NOOP -> DONE with succ=1. Illegal -> DONE with succ=0.
  - op_valid_in while ready_out=0 is ignored.
- SEARCH:
  - Exactly NUM_ENTRIES cycles; cycle i examines entry i.
  - Valid entry with key match -> record hit index. Keys are unique, so at most one hit.
  - Invalid entry and no free slot recorded yet -> record it as lowest free index.
  - After entry NUM_ENTRIES-1 -> COMMIT. No early exit; latency is fixed.
- COMMIT (one cycle):
  - GET hit: result<=value[hit], succ=1. GET miss: result<=0, succ=0.
  - UPSERT hit: value[hit]<=value_in, succ=1.
  - UPSERT miss with free slot: write key/value, set valid, occupancy+1, succ=1.
  - UPSERT miss with store full: no write, succ=0.
  - DELETE hit: valid<=0, occupancy-1, succ=1. DELETE miss: succ=0.
  - Non-GET ops leave result_value_out at 0.
- DONE (one cycle): done_out=1, ready_out=0; -> IDLE.
- Latency:
  - Capture edge to done_out high = NUM_ENTRIES+2 cycles for searched ops; 1 cycle for NOOP/illegal.
  - ready_out returns high the cycle after done_out.
- op_succ_out and result_value_out update only in COMMIT (or on the IDLE->DONE path) and are stable while done_out=1.
- occupancy_out is never outside 0..NUM_ENTRIES; all arithmetic is unsigned.

Optional Feature:
- CACHE_CTRL_STATS_EN defined: adds outputs hit_count_out[31:0] and miss_count_out[31:0].
  - Both reset to 0; incremented in COMMIT for GET/UPSERT/DELETE on hit or miss respectively.
  - Saturate at 32'hFFFF_FFFF.
- Undefined: those ports and counters do not exist; all other behaviour is identical.

Decomposition:
- ctrl_types_pkg: operation_e (including OP codes), ctrl_state_e {IDLE, SEARCH, COMMIT, DONE}, cache_entry_t struct {valid, key, value}.
- Sub-module cache_entry_store holds the entry array:
  - One combinational read port indexed by scan index.
  - One write port (index, key, value, set/clear valid).
  - Valid bits async-cleared on rst.
- FSM and counters stay in cache_kv_controller.

Test Plan (NUM_ENTRIES=4):
- Reset then GET key 0x5 -> done_out 6 cycles after capture, op_succ_out=0, result=0, occupancy=0.
- UPSERT key 0x5 value 0xAB, then GET 0x5 -> succ=1, result_value_out=0xAB, occupancy=1.
- UPSERT keys 1,2,3,4, then a fifth UPSERT key 9 -> succ=0, occupancy stays 4; GET 9 -> succ=0.
- DELETE key 2, then UPSERT key 9 -> key 9 lands in slot 1 (lowest free); GET 9 succ=1, occupancy=4; DELETE 2 again -> succ=0.
- Illegal op 3'd6 -> done_out 1 cycle after capture, succ=0; op_valid_in pulsed during SEARCH -> ignored, single done_out.
- Assert rst during SEARCH of an UPSERT -> immediate IDLE, ready_out=1, occupancy=0, no done_out; following GET of that key -> succ=0.

Source files
------------

// File: rtl/ctrl_types_pkg.sv
// Shared types for the key/value cache controller: operation codes, FSM states, entry layout.
package ctrl_types_pkg;

    localparam int unsigned DEF_ARCHITECTURE = 64;

    typedef enum logic [2:0] {
        OP_NOOP   = 3'd0,
        OP_GET    = 3'd1,
        OP_UPSERT = 3'd2,
        OP_DELETE = 3'd3
    } operation_e;

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        COMMIT,
        DONE
    } ctrl_state_e;

    typedef struct packed {
        logic                            valid;
        logic [DEF_ARCHITECTURE-4:0]     key;
        logic [2*DEF_ARCHITECTURE-1:0]   value;
    } cache_entry_t;

    // Codes 4-7 are illegal and never start a search.
    function automatic logic is_search_op(logic [2:0] op);
        return (op == OP_GET) || (op == OP_UPSERT) || (op == OP_DELETE);
    endfunction

endpackage

// File: rtl/cache_entry_store.sv
// Fully-associative entry array: one combinational read port, one write port, async-cleared valids.
module cache_entry_store #(
    parameter int unsigned NUM_ENTRIES = 8,
    parameter int unsigned KEY_W       = 61,
    parameter int unsigned VAL_W       = 128,
    parameter int unsigned IDX_W       = $clog2(NUM_ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_valid,
    output logic [KEY_W-1:0] rd_key,
    output logic [VAL_W-1:0] rd_value,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [KEY_W-1:0] wr_key,
    input  logic [VAL_W-1:0] wr_value,
    input  logic             set_valid,
    input  logic             clr_valid
);

    logic [NUM_ENTRIES-1:0] valid_q;
    logic [KEY_W-1:0]       key_q   [NUM_ENTRIES];
    logic [VAL_W-1:0]       value_q [NUM_ENTRIES];

    // Payload needs no reset; only the valid bits define store contents.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            key_q[wr_idx]   <= wr_key;
            value_q[wr_idx] <= wr_value;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else if (set_valid) begin
            valid_q[wr_idx] <= 1'b1;
        end else if (clr_valid) begin
            valid_q[wr_idx] <= 1'b0;
        end
    end

    always_comb begin
        rd_valid = valid_q[rd_idx];
        rd_key   = key_q[rd_idx];
        rd_value = value_q[rd_idx];
    end

endmodule

// File: rtl/cache_kv_controller.sv
// Key/value cache controller with fixed-latency linear search over cache_entry_store.
// Optional hit/miss statistics outputs are enabled by defining CACHE_CTRL_STATS_EN.
module cache_kv_controller
    import ctrl_types_pkg::*;
#(
    parameter int unsigned ARCHITECTURE = 64,
    parameter int unsigned NUM_ENTRIES  = 8,
    parameter int unsigned IDX_W        = $clog2(NUM_ENTRIES)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        op_valid_in,
    input  logic [2:0]                  operation_in,
    input  logic [ARCHITECTURE-4:0]     key_in,
    input  logic [2*ARCHITECTURE-1:0]   value_in,
    output logic                        ready_out,
    output logic                        done_out,
    output logic                        op_succ_out,
    output logic [2*ARCHITECTURE-1:0]   result_value_out,
    output logic [IDX_W:0]              occupancy_out
`ifdef CACHE_CTRL_STATS_EN
    ,
    output logic [31:0]                 hit_count_out,
    output logic [31:0]                 miss_count_out
`endif
);

    localparam int unsigned KEY_W = ARCHITECTURE - 3;
    localparam int unsigned VAL_W = 2 * ARCHITECTURE;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

    ctrl_state_e      state_q, state_d;
    operation_e       op_q, op_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic [VAL_W-1:0] value_q, value_d;
    logic [IDX_W-1:0] scan_q, scan_d;
    logic             hit_q, hit_d;
    logic [IDX_W-1:0] hit_idx_q, hit_idx_d;
    logic             free_q, free_d;
    logic [IDX_W-1:0] free_idx_q, free_idx_d;
    logic             succ_q, succ_d;
    logic [VAL_W-1:0] result_q, result_d;
    logic [IDX_W:0]   occ_q, occ_d;

    logic [IDX_W-1:0] rd_idx;
    logic             rd_valid;
    logic [KEY_W-1:0] rd_key;
    logic [VAL_W-1:0] rd_value;
    logic             wr_en, set_valid, clr_valid;
    logic [IDX_W-1:0] wr_idx;
    logic             stat_hit, stat_miss;

    // The single read port scans during SEARCH and fetches the hit entry in COMMIT.
    assign rd_idx = (state_q == COMMIT) ? hit_idx_q : scan_q;

    cache_entry_store #(
        .NUM_ENTRIES (NUM_ENTRIES),
        .KEY_W       (KEY_W),
        .VAL_W       (VAL_W),
        .IDX_W       (IDX_W)
    ) u_store (
        .clk       (clk),
        .rst       (rst),
        .rd_idx    (rd_idx),
        .rd_valid  (rd_valid),
        .rd_key    (rd_key),
        .rd_value  (rd_value),
        .wr_en     (wr_en),
        .wr_idx    (wr_idx),
        .wr_key    (key_q),
        .wr_value  (value_q),
        .set_valid (set_valid),
        .clr_valid (clr_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            op_q       <= OP_NOOP;
            key_q      <= '0;
            value_q    <= '0;
            scan_q     <= '0;
            hit_q      <= 1'b0;
            hit_idx_q  <= '0;
            free_q     <= 1'b0;
            free_idx_q <= '0;
            succ_q     <= 1'b0;
            result_q   <= '0;
            occ_q      <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            key_q      <= key_d;
            value_q    <= value_d;
            scan_q     <= scan_d;
            hit_q      <= hit_d;
            hit_idx_q  <= hit_idx_d;
            free_q     <= free_d;
            free_idx_q <= free_idx_d;
            succ_q     <= succ_d;
            result_q   <= result_d;
            occ_q      <= occ_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        key_d      = key_q;
        value_d    = value_q;
        scan_d     = scan_q;
        hit_d      = hit_q;
        hit_idx_d  = hit_idx_q;
        free_d     = free_q;
        free_idx_d = free_idx_q;
        succ_d     = succ_q;
        result_d   = result_q;
        occ_d      = occ_q;
        wr_en      = 1'b0;
        wr_idx     = hit_idx_q;
        set_valid  = 1'b0;
        clr_valid  = 1'b0;
        stat_hit   = 1'b0;
        stat_miss  = 1'b0;
        ready_out  = 1'b0;
        done_out   = 1'b0;

        unique case (state_q)
            IDLE: begin
                ready_out = 1'b1;
                if (op_valid_in) begin
                    op_d    = operation_e'(operation_in);
                    key_d   = key_in;
                    value_d = value_in;
                    hit_d   = 1'b0;
                    free_d  = 1'b0;
                    scan_d  = '0;
                    if (is_search_op(operation_in)) begin
                        state_d = SEARCH;
                    end else begin
                        state_d  = DONE;
                        succ_d   = (operation_in == OP_NOOP);
                        result_d = '0;
                    end
                end
            end
            SEARCH: begin
                if (rd_valid && (rd_key == key_q)) begin
                    hit_d     = 1'b1;
                    hit_idx_d = scan_q;
                end else if (!rd_valid && !free_q) begin
                    free_d     = 1'b1;
                    free_idx_d = scan_q;
                end
                if (scan_q == LAST_IDX) begin
                    state_d = COMMIT;
                end else begin
                    scan_d = scan_q + IDX_W'(1);
                end
            end
            COMMIT: begin
                state_d   = DONE;
                result_d  = '0;
                stat_hit  = hit_q;
                stat_miss = !hit_q;
                case (op_q)
                    OP_GET: begin
                        succ_d = hit_q;
                        if (hit_q) result_d = rd_value;
                    end
                    OP_UPSERT: begin
                        if (hit_q) begin
                            wr_en  = 1'b1;
                            succ_d = 1'b1;
                        end else if (free_q) begin
                            wr_en     = 1'b1;
                            wr_idx    = free_idx_q;
                            set_valid = 1'b1;
                            occ_d     = occ_q + (IDX_W+1)'(1);
                            succ_d    = 1'b1;
                        end else begin
                            succ_d = 1'b0;
                        end
                    end
                    OP_DELETE: begin
                        succ_d = hit_q;
                        if (hit_q) begin
                            clr_valid = 1'b1;
                            occ_d     = occ_q - (IDX_W+1)'(1);
                        end
                    end
                    default: succ_d = 1'b0;
                endcase
            end
            DONE: begin
                done_out = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign op_succ_out      = succ_q;
    assign result_value_out = result_q;
    assign occupancy_out    = occ_q;

`ifdef CACHE_CTRL_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (stat_hit && (hit_cnt_q != 32'hFFFF_FFFF)) hit_cnt_q <= hit_cnt_q + 32'd1;
            if (stat_miss && (miss_cnt_q != 32'hFFFF_FFFF)) miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign hit_count_out  = hit_cnt_q;
    assign miss_count_out = miss_cnt_q;
`else
    logic unused_stats;
    assign unused_stats = stat_hit ^ stat_miss;
`endif

endmodule

// File: tb/tb_cache_kv_controller.sv
// Self-checking bench: directed scenarios plus random ops against a behavioural key/value model.
module tb_cache_kv_controller;

    localparam int unsigned ARCH = 64;
    localparam int unsigned N    = 4;
    localparam int unsigned IW   = $clog2(N);

    logic            clk;
    logic            rst;
    logic            op_valid_in;
    logic [2:0]      operation_in;
    logic [ARCH-4:0] key_in;
    logic [2*ARCH-1:0] value_in;
    logic            ready_out;
    logic            done_out;
    logic            op_succ_out;
    logic [2*ARCH-1:0] result_value_out;
    logic [IW:0]     occupancy_out;

    int checks = 0;
    int errors = 0;

    // Behavioural store: slot-indexed so "lowest free slot" placement is modelled.
    bit              m_valid [N];
    logic [ARCH-4:0] m_key   [N];
    logic [2*ARCH-1:0] m_val [N];

    cache_kv_controller #(
        .ARCHITECTURE (ARCH),
        .NUM_ENTRIES  (N)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .op_valid_in      (op_valid_in),
        .operation_in     (operation_in),
        .key_in           (key_in),
        .value_in         (value_in),
        .ready_out        (ready_out),
        .done_out         (done_out),
        .op_succ_out      (op_succ_out),
        .result_value_out (result_value_out),
        .occupancy_out    (occupancy_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_count();
        int c = 0;
        for (int i = 0; i < N; i++) if (m_valid[i]) c++;
        return c;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
    endfunction

    function automatic void model_exec(input logic [2:0] op, input logic [ARCH-4:0] k,
                                       input logic [2*ARCH-1:0] v, output logic s,
                                       output logic [2*ARCH-1:0] r);
        int hit = -1;
        int fr  = -1;
        for (int i = 0; i < N; i++) if (m_valid[i] && m_key[i] == k) hit = i;
        for (int i = N - 1; i >= 0; i--) if (!m_valid[i]) fr = i;
        r = '0;
        s = 1'b0;
        case (op)
            3'd0: s = 1'b1;
            3'd1: begin
                s = (hit >= 0);
                if (hit >= 0) r = m_val[hit];
            end
            3'd2: begin
                if (hit >= 0) begin
                    m_val[hit] = v;
                    s = 1'b1;
                end else if (fr >= 0) begin
                    m_valid[fr] = 1'b1;
                    m_key[fr]   = k;
                    m_val[fr]   = v;
                    s = 1'b1;
                end
            end
            3'd3: begin
                if (hit >= 0) begin
                    m_valid[hit] = 1'b0;
                    s = 1'b1;
                end
            end
            default: s = 1'b0;
        endcase
    endfunction

    // Issue one op, measure capture-to-done latency, compare outputs with the model.
    // poke=1 pulses op_valid_in mid-search, which must be ignored.
    task automatic run_op(input logic [2:0] op, input logic [ARCH-4:0] k,
                          input logic [2*ARCH-1:0] v, input bit poke);
        logic              exp_s;
        logic [2*ARCH-1:0] exp_r;
        int                exp_lat;
        int                cyc;
        int                w;
        w = 0;
        while (!ready_out && w < 20) begin
            @(posedge clk); #1; w++;
        end
        check("ready_before_op", ready_out, 1'b1);
        model_exec(op, k, v, exp_s, exp_r);
        exp_lat = (op >= 3'd1 && op <= 3'd3) ? N + 2 : 1;
        op_valid_in  = 1'b1;
        operation_in = op;
        key_in       = k;
        value_in     = v;
        @(posedge clk); #1;
        op_valid_in = 1'b0;
        cyc = 1;
        while (!done_out && cyc < 40) begin
            if (poke && cyc == 2) begin
                op_valid_in  = 1'b1;
                operation_in = 3'd1;
            end else begin
                op_valid_in = 1'b0;
            end
            @(posedge clk); #1; cyc++;
        end
        op_valid_in = 1'b0;
        check("latency", cyc, exp_lat);
        check("op_succ", op_succ_out, exp_s);
        check("result", result_value_out, exp_r);
        check("occupancy", occupancy_out, model_count());
        @(posedge clk); #1;
        check("done_single_pulse", done_out, 1'b0);
        check("ready_after_done", ready_out, 1'b1);
        check("succ_held", op_succ_out, exp_s);
    endtask

    task automatic idle_no_done(input string tag, input int ncyc);
        int seen = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clk); #1;
            if (done_out) seen++;
        end
        check(tag, seen, 0);
    endtask

    initial begin
        logic [2:0] rop;
        int         sel;
        model_clear();
        rst          = 1'b1;
        op_valid_in  = 1'b0;
        operation_in = 3'd0;
        key_in       = '0;
        value_in     = '0;
        #12;
        check("rst_ready", ready_out, 1'b1);
        check("rst_done", done_out, 1'b0);
        check("rst_succ", op_succ_out, 1'b0);
        check("rst_result", result_value_out, 128'd0);
        check("rst_occupancy", occupancy_out, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // Empty-store GET, then insert and read back.
        run_op(3'd1, 61'h5, '0, 1'b0);
        run_op(3'd2, 61'h5, 128'hAB, 1'b0);
        run_op(3'd1, 61'h5, '0, 1'b0);

        // Fill the store, overflow it, then free a slot and refill.
        run_op(3'd3, 61'h5, '0, 1'b0);
        for (int i = 1; i <= 4; i++) run_op(3'd2, 61'(i), 128'(i * 32'h1111), 1'b0);
        run_op(3'd2, 61'h9, 128'h99, 1'b0);
        run_op(3'd1, 61'h9, '0, 1'b0);
        run_op(3'd3, 61'h2, '0, 1'b0);
        run_op(3'd2, 61'h9, 128'h99, 1'b0);
        run_op(3'd1, 61'h9, '0, 1'b0);
        run_op(3'd1, 61'h3, '0, 1'b0);
        run_op(3'd3, 61'h2, '0, 1'b0);
        run_op(3'd2, 61'h1, 128'hDEAD_BEEF_0123, 1'b0);
        run_op(3'd1, 61'h1, '0, 1'b0);

        // Illegal op, NOOP, and a strobe during SEARCH.
        run_op(3'd6, 61'h1, '0, 1'b0);
        run_op(3'd0, 61'h1, '0, 1'b0);
        run_op(3'd1, 61'h4, '0, 1'b1);
        idle_no_done("poke_ignored", 10);

        // Reset in the middle of an UPSERT search.
        op_valid_in  = 1'b1;
        operation_in = 3'd2;
        key_in       = 61'h77;
        value_in     = 128'h7777;
        @(posedge clk); #1;
        op_valid_in = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        model_clear();
        check("midrst_ready", ready_out, 1'b1);
        check("midrst_occupancy", occupancy_out, 0);
        check("midrst_done", done_out, 1'b0);
        check("midrst_succ", op_succ_out, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        idle_no_done("midrst_no_done", 10);
        run_op(3'd1, 61'h77, '0, 1'b0);

        // Random traffic over a small key space so hits, misses and full-store cases all occur.
        for (int n = 0; n < 60; n++) begin
            sel = $urandom_range(0, 9);
            if (sel < 3)       rop = 3'd1;
            else if (sel < 6)  rop = 3'd2;
            else if (sel < 8)  rop = 3'd3;
            else if (sel == 8) rop = 3'd0;
            else               rop = 3'($urandom_range(4, 7));
            run_op(rop, 61'($urandom_range(1, 6)), {$urandom, $urandom, $urandom, $urandom},
                   1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
